// File: rtl/score_pkg.sv
// score_pkg: shared score width and winning score for the score keeper.
package score_pkg;
  localparam int M_SCORE_W = 4;
  localparam logic [M_SCORE_W-1:0] MAX_SCORE = 4'd11;
endpackage

// File: rtl/score_if.sv
// score_if: game-control inputs and score/ball outputs of the score keeper.
interface score_if;
  import score_pkg::*;
  logic game_en_i;
  logic p_goal_i;
  logic e_goal_i;
  logic [M_SCORE_W-1:0] p_score_o;
  logic [M_SCORE_W-1:0] e_score_o;
  logic ball_rst_o;
  logic ball_en_o;
  logic serve_dir_o;
  modport master(
    output game_en_i, p_goal_i, e_goal_i,
    input  p_score_o, e_score_o, ball_rst_o, ball_en_o, serve_dir_o
  );
  modport slave(
    input  game_en_i, p_goal_i, e_goal_i,
    output p_score_o, e_score_o, ball_rst_o, ball_en_o, serve_dir_o
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: serve/rally/score FSM for a two-sided ball game.
// Define SCORE_KEEPER_SERVE_ALTERNATE_EN to flip the serve side after every accepted goal.
module score_keeper
  import score_pkg::*;
#(
  parameter int SERVE_CYCLES = 50_000_000
) (
  input  logic    clk_i,
  input  logic    rst_i,
  score_if.slave  sif
);
`ifdef SCORE_KEEPER_SERVE_ALTERNATE_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif
  localparam int TW = $clog2(SERVE_CYCLES + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_RALLY, ST_OVER} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [M_SCORE_W-1:0] p_score, e_score, p_next, e_next;
  logic ball_rst, ball_en, serve_dir;
  logic p_only, e_only, both, goal, win;
  always_comb begin
    p_only = sif.p_goal_i & ~sif.e_goal_i;
    e_only = sif.e_goal_i & ~sif.p_goal_i;
    both   = sif.p_goal_i & sif.e_goal_i;
    goal   = sif.p_goal_i | sif.e_goal_i;
    p_next = (p_score == MAX_SCORE) ? p_score : p_score + 1'b1;
    e_next = (e_score == MAX_SCORE) ? e_score : e_score + 1'b1;
    win    = (p_only && p_next == MAX_SCORE) || (e_only && e_next == MAX_SCORE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      p_score   <= '0;
      e_score   <= '0;
      ball_rst  <= 1'b0;
      ball_en   <= 1'b0;
      serve_dir <= 1'b1;
      timer     <= '0;
    end else if (!sif.game_en_i) begin
      state    <= ST_IDLE;
      ball_rst <= 1'b0;
      ball_en  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          p_score   <= '0;
          e_score   <= '0;
          timer     <= TW'(SERVE_CYCLES);
          ball_rst  <= 1'b1;
          serve_dir <= 1'b1;
          state     <= ST_SERVE;
        end
        ST_SERVE: begin
          ball_rst <= 1'b0;
          timer    <= timer - 1'b1;
          if (timer == TW'(1)) begin
            state   <= ST_RALLY;
            ball_en <= 1'b1;
          end
        end
        ST_RALLY: if (goal) begin
          ball_en  <= 1'b0;
          ball_rst <= ~win;
          state    <= win ? ST_OVER : ST_SERVE;
          timer    <= win ? timer : TW'(SERVE_CYCLES);
          if (p_only) p_score <= p_next;
          if (e_only) e_score <= e_next;
          // a tie (both goals at once) leaves the serve side alone
          if (!both) serve_dir <= ALT ? ~serve_dir : e_only;
        end
        ST_OVER: ball_en <= 1'b0;
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign sif.p_score_o   = p_score;
  assign sif.e_score_o   = e_score;
  assign sif.ball_rst_o  = ball_rst;
  assign sif.ball_en_o   = ball_en;
  assign sif.serve_dir_o = serve_dir;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scenario tests for score_keeper with SERVE_CYCLES=4.
module tb_score_keeper;
  import score_pkg::*;
`ifdef SCORE_KEEPER_SERVE_ALTERNATE_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int passed = 0;
  int total = 0;
  score_if sif();
  score_keeper #(.SERVE_CYCLES(4)) dut(.clk_i(clk_i), .rst_i(rst_i), .sif(sif));
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // counts ball_en_o=0 cycles, starting at the current one, until the rally begins
  task automatic wait_rally(output int zeros);
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      if (sif.ball_en_o) break;
      zeros++;
      step();
    end
  endtask

  task automatic test_reset();
    sif.game_en_i = 1'b0; sif.p_goal_i = 1'b0; sif.e_goal_i = 1'b0;
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    total++;
    if ({sif.p_score_o, sif.e_score_o} !== '0) $display("FAIL reset_scores got %0d/%0d want 0/0", sif.p_score_o, sif.e_score_o); else passed++;
    total++;
    if ({sif.ball_rst_o, sif.ball_en_o, sif.serve_dir_o} !== 3'b001) $display("FAIL reset_flags got rst/en/dir=%b want 001", {sif.ball_rst_o, sif.ball_en_o, sif.serve_dir_o}); else passed++;
  endtask

  task automatic test_start();
    int z, pulses;
    sif.game_en_i = 1'b1;
    step();
    total++;
    if (sif.ball_rst_o !== 1'b1 || sif.ball_en_o !== 1'b0) $display("FAIL start_pulse got rst=%b en=%b want 1 0", sif.ball_rst_o, sif.ball_en_o); else passed++;
    pulses = 1;
    z = 0;
    for (int i = 0; i < 20 && !sif.ball_en_o; i++) begin
      z++;
      step();
      if (sif.ball_rst_o) pulses++;
    end
    total++;
    if (z !== 4) $display("FAIL start_serve_len got %0d want 4", z); else passed++;
    total++;
    if (pulses !== 1) $display("FAIL start_pulse_count got %0d want 1", pulses); else passed++;
    total++;
    if ({sif.p_score_o, sif.e_score_o} !== '0) $display("FAIL start_scores got %0d/%0d want 0/0", sif.p_score_o, sif.e_score_o); else passed++;
  endtask

  // goal level raised at game start and held 10 cycles spans a whole serve and one rally edge
  task automatic test_held_goal();
    int pulses, zeros;
    sif.game_en_i = 1'b0;
    step();
    sif.game_en_i = 1'b1;
    sif.p_goal_i = 1'b1;
    pulses = 0; zeros = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 1 && sif.ball_rst_o) pulses++;
      if (i >= 5 && !sif.ball_en_o) zeros++;
    end
    sif.p_goal_i = 1'b0;
    total++;
    if (sif.p_score_o !== 4'd1 || sif.e_score_o !== 4'd0) $display("FAIL held_goal_score got %0d/%0d want 1/0", sif.p_score_o, sif.e_score_o); else passed++;
    total++;
    if (pulses !== 1) $display("FAIL held_goal_pulses got %0d want 1", pulses); else passed++;
    total++;
    if (zeros !== 4 || sif.ball_en_o !== 1'b1) $display("FAIL held_goal_serve got %0d en=%b want 4 1", zeros, sif.ball_en_o); else passed++;
    total++;
    if (sif.serve_dir_o !== (ALT ? 1'b0 : 1'b0)) $display("FAIL held_goal_dir got %b want 0", sif.serve_dir_o); else passed++;
  endtask

  task automatic test_max();
    int z, bad, pulses;
    for (int i = 0; i < 20 && sif.p_score_o != MAX_SCORE - 1; i++) begin
      sif.p_goal_i = 1'b1;
      step();
      sif.p_goal_i = 1'b0;
      wait_rally(z);
    end
    total++;
    if (sif.p_score_o !== 4'd10) $display("FAIL max_pre got %0d want 10", sif.p_score_o); else passed++;
    sif.p_goal_i = 1'b1;
    step();
    total++;
    if (sif.p_score_o !== 4'd11 || sif.ball_en_o !== 1'b0 || sif.ball_rst_o !== 1'b0) $display("FAIL max_reach got %0d en=%b rst=%b want 11 0 0", sif.p_score_o, sif.ball_en_o, sif.ball_rst_o); else passed++;
    bad = 0; pulses = 0;
    for (int i = 0; i < 100; i++) begin
      sif.p_goal_i = i[0];
      sif.e_goal_i = i[1];
      step();
      if (sif.ball_en_o || sif.p_score_o != 4'd11 || sif.e_score_o != 4'd0) bad++;
      if (sif.ball_rst_o) pulses++;
    end
    sif.p_goal_i = 1'b0; sif.e_goal_i = 1'b0;
    total++;
    if (bad !== 0) $display("FAIL over_hold got %0d bad cycles want 0", bad); else passed++;
    total++;
    if (pulses !== 0) $display("FAIL over_no_restart got %0d pulses want 0", pulses); else passed++;
  endtask

  task automatic test_both_goals();
    int z;
    sif.game_en_i = 1'b0;
    step();
    sif.game_en_i = 1'b1;
    step();
    total++;
    if (sif.ball_rst_o !== 1'b1 || sif.p_score_o !== 4'd0 || sif.serve_dir_o !== 1'b1) $display("FAIL restart got rst=%b p=%0d dir=%b want 1 0 1", sif.ball_rst_o, sif.p_score_o, sif.serve_dir_o); else passed++;
    wait_rally(z);
    sif.p_goal_i = 1'b1;
    step();
    sif.p_goal_i = 1'b0;
    wait_rally(z);
    sif.p_goal_i = 1'b1; sif.e_goal_i = 1'b1;
    step();
    sif.p_goal_i = 1'b0; sif.e_goal_i = 1'b0;
    total++;
    if (sif.p_score_o !== 4'd1 || sif.e_score_o !== 4'd0) $display("FAIL both_scores got %0d/%0d want 1/0", sif.p_score_o, sif.e_score_o); else passed++;
    total++;
    if (sif.serve_dir_o !== 1'b0 || sif.ball_rst_o !== 1'b1 || sif.ball_en_o !== 1'b0) $display("FAIL both_reserve got dir=%b rst=%b en=%b want 0 1 0", sif.serve_dir_o, sif.ball_rst_o, sif.ball_en_o); else passed++;
    wait_rally(z);
    total++;
    if (z !== 4) $display("FAIL both_serve_len got %0d want 4", z); else passed++;
  endtask

  task automatic test_disable();
    int z;
    sif.game_en_i = 1'b0;
    step();
    total++;
    if (sif.ball_en_o !== 1'b0 || sif.p_score_o !== 4'd1) $display("FAIL disable_stop got en=%b p=%0d want 0 1", sif.ball_en_o, sif.p_score_o); else passed++;
    repeat (3) step();
    total++;
    if (sif.p_score_o !== 4'd1 || sif.e_score_o !== 4'd0) $display("FAIL disable_hold got %0d/%0d want 1/0", sif.p_score_o, sif.e_score_o); else passed++;
    sif.game_en_i = 1'b1;
    step();
    total++;
    if (sif.p_score_o !== 4'd0 || sif.ball_rst_o !== 1'b1 || sif.serve_dir_o !== 1'b1) $display("FAIL reenable got p=%0d rst=%b dir=%b want 0 1 1", sif.p_score_o, sif.ball_rst_o, sif.serve_dir_o); else passed++;
    wait_rally(z);
    total++;
    if (z !== 4) $display("FAIL reenable_serve_len got %0d want 4", z); else passed++;
  endtask

  task automatic test_serve_dir();
    int z;
    sif.e_goal_i = 1'b1;
    step();
    sif.e_goal_i = 1'b0;
    total++;
    if (sif.serve_dir_o !== (ALT ? 1'b0 : 1'b1) || sif.e_score_o !== 4'd1) $display("FAIL dir_first got dir=%b e=%0d want %b 1", sif.serve_dir_o, sif.e_score_o, ALT ? 1'b0 : 1'b1); else passed++;
    wait_rally(z);
    sif.e_goal_i = 1'b1;
    step();
    sif.e_goal_i = 1'b0;
    total++;
    if (sif.serve_dir_o !== 1'b1 || sif.e_score_o !== 4'd2) $display("FAIL dir_second got dir=%b e=%0d want 1 2", sif.serve_dir_o, sif.e_score_o); else passed++;
    wait_rally(z);
  endtask

  task automatic test_reset_mid();
    rst_i = 1'b1;
    sif.p_goal_i = 1'b1;
    step();
    rst_i = 1'b0;
    sif.p_goal_i = 1'b0;
    total++;
    if (sif.p_score_o !== 4'd0 || sif.e_score_o !== 4'd0 || sif.ball_en_o !== 1'b0 || sif.serve_dir_o !== 1'b1) $display("FAIL reset_mid got p=%0d e=%0d en=%b dir=%b want 0 0 0 1", sif.p_score_o, sif.e_score_o, sif.ball_en_o, sif.serve_dir_o); else passed++;
    step();
    total++;
    if (sif.ball_rst_o !== 1'b1) $display("FAIL reset_mid_restart got rst=%b want 1", sif.ball_rst_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_held_goal();
    test_max();
    test_both_goals();
    test_disable();
    test_serve_dir();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
